// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage CPU pipeline: ALU op codes, the
// control-bit layout of the 5-bit ctl vector, and default datapath widths.
package cpu_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned RW_DEF   = 5;
  localparam int unsigned CTL_W    = 5;
  localparam int unsigned ALU_OP_W = 3;

  // ALU operation codes
  typedef enum logic [ALU_OP_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b100,
    ALU_SUB = 3'b110,
    ALU_NOP = 3'b111
  } alu_op_e;

  // Bit positions inside the ctl vector {reg_write,mem_read,mem_write,mem_to_reg,branch}
  localparam int unsigned CTL_BRANCH     = 0;
  localparam int unsigned CTL_MEM_TO_REG = 1;
  localparam int unsigned CTL_MEM_WRITE  = 2;
  localparam int unsigned CTL_MEM_READ   = 3;
  localparam int unsigned CTL_REG_WRITE  = 4;

  // Same layout as the ctl vector (first field is the MSB)
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctl_t;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one source register.
// Ports: src_i (source index), reg_data_i (registered read data),
//        exm_* / mw_* (EX/MEM and MEM/WB writeback candidates), data_o.
// Priority: EX/MEM, then MEM/WB, then register data; $0 is never forwarded.
module fwd_sel #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] src_i,
  input  logic [DW-1:0] reg_data_i,
  input  logic          exm_reg_write_i,
  input  logic [RW-1:0] exm_rd_i,
  input  logic [DW-1:0] exm_res_i,
  input  logic          mw_reg_write_i,
  input  logic [RW-1:0] mw_rd_i,
  input  logic [DW-1:0] mw_wdata_i,
  output logic [DW-1:0] data_o
);

  logic src_nz;
  assign src_nz = (src_i != '0);

  always_comb begin : sel
    data_o = reg_data_i;
    if (exm_reg_write_i && src_nz && (exm_rd_i == src_i)) begin
      data_o = exm_res_i;
    end else if (mw_reg_write_i && src_nz && (mw_rd_i == src_i)) begin
      data_o = mw_wdata_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
// Inputs : clk, rst_n, stall, flush, id_* (decoded ID slot),
//          exm_* (EX/MEM writeback), mw_* (MEM/WB writeback).
// Outputs: ex_valid, alu_in1/alu_in2, alu_ctr, ex_store_data, ex_rd, ex_ctl,
//          load_use_haz (combinational, to the hazard unit).
// Build option ID_EX_FWD_EN: when defined, operands are forwarded from
// EX/MEM and MEM/WB and only load-use hazards bubble; when undefined, the
// forwarding enables are tied low and every RAW hazard on EX or EX/MEM bubbles.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [2:0]    id_alu_ctr,
  input  logic          id_alu_src,
  input  logic [4:0]    id_ctl,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_res,
  input  logic          mw_reg_write,
  input  logic [RW-1:0] mw_rd,
  input  logic [DW-1:0] mw_wdata,
  output logic          ex_valid,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [2:0]    alu_ctr,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic [4:0]    ex_ctl,
  output logic          load_use_haz
);

  logic          valid_q,    valid_d;
  ctl_t          ctl_q,      ctl_d;
  logic [RW-1:0] rd_q,       rd_d;
  logic [2:0]    alu_ctr_q,  alu_ctr_d;
  logic [RW-1:0] rs_q,       rs_d;
  logic [RW-1:0] rt_q,       rt_d;
  logic [DW-1:0] rs_data_q,  rs_data_d;
  logic [DW-1:0] rt_data_q,  rt_data_d;
  logic [DW-1:0] imm_q,      imm_d;
  logic          alu_src_q,  alu_src_d;
  logic          bubble;

  logic          fwd_exm_we;
  logic          fwd_mw_we;
  logic [DW-1:0] rs_fwd;
  logic [DW-1:0] rt_fwd;
  logic          ex_match;

  // EX-slot destination matches one of the ID sources
  assign ex_match = id_valid && ((rd_q == id_rs) || (rd_q == id_rt));

`ifdef ID_EX_FWD_EN
  assign fwd_exm_we = exm_reg_write;
  assign fwd_mw_we  = mw_reg_write;

  // Only a load in EX cannot be forwarded in time
  assign load_use_haz = valid_q && ctl_q.mem_read && (rd_q != '0) && ex_match;
`else
  // Forwarding disabled: enables tied low so the muxes fold to register data
  assign fwd_exm_we = 1'b0;
  assign fwd_mw_we  = 1'b0;

  // Any producer still in EX or EX/MEM forces a bubble
  assign load_use_haz =
      (valid_q && ctl_q.reg_write && (rd_q != '0) && ex_match) ||
      (exm_reg_write && (exm_rd != '0) && id_valid &&
       ((exm_rd == id_rs) || (exm_rd == id_rt)));

  logic unused_nofwd;
  assign unused_nofwd = mw_reg_write;
`endif

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src_i           (rs_q),
    .reg_data_i      (rs_data_q),
    .exm_reg_write_i (fwd_exm_we),
    .exm_rd_i        (exm_rd),
    .exm_res_i       (exm_res),
    .mw_reg_write_i  (fwd_mw_we),
    .mw_rd_i         (mw_rd),
    .mw_wdata_i      (mw_wdata),
    .data_o          (rs_fwd)
  );

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src_i           (rt_q),
    .reg_data_i      (rt_data_q),
    .exm_reg_write_i (fwd_exm_we),
    .exm_rd_i        (exm_rd),
    .exm_res_i       (exm_res),
    .mw_reg_write_i  (fwd_mw_we),
    .mw_rd_i         (mw_rd),
    .mw_wdata_i      (mw_wdata),
    .data_o          (rt_fwd)
  );

  // Next state: flush > stall > hazard > capture; an empty ID slot also bubbles
  always_comb begin : next_state
    valid_d   = valid_q;
    ctl_d     = ctl_q;
    rd_d      = rd_q;
    alu_ctr_d = alu_ctr_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    alu_src_d = alu_src_q;
    bubble    = 1'b0;

    if (flush) begin
      bubble = 1'b1;
    end else if (!stall) begin
      if (load_use_haz) begin
        bubble = 1'b1;
      end else begin
        rs_d      = id_rs;
        rt_d      = id_rt;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm;
        alu_src_d = id_alu_src;
        if (id_valid) begin
          valid_d   = 1'b1;
          ctl_d     = ctl_t'(id_ctl);
          rd_d      = id_rd;
          alu_ctr_d = id_alu_ctr;
        end else begin
          bubble = 1'b1;
        end
      end
    end

    if (bubble) begin
      valid_d   = 1'b0;
      ctl_d     = '0;
      rd_d      = '0;
      alu_ctr_d = ALU_NOP;
    end
  end

  // Pipeline register
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctl_q     <= '0;
      rd_q      <= '0;
      alu_ctr_q <= ALU_NOP;
      rs_q      <= '0;
      rt_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      alu_src_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      ctl_q     <= ctl_d;
      rd_q      <= rd_d;
      alu_ctr_q <= alu_ctr_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      alu_src_q <= alu_src_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_ctl        = 5'(ctl_q);
  assign ex_rd         = rd_q;
  assign alu_ctr       = alu_ctr_q;
  assign alu_in1       = rs_fwd;
  assign alu_in2       = alu_src_q ? imm_q : rt_fwd;
  assign ex_store_data = rt_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_alu_ctr;
  logic        id_alu_src;
  logic [4:0]  id_ctl;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_res;
  logic        mw_reg_write;
  logic [4:0]  mw_rd;
  logic [31:0] mw_wdata;
  logic        ex_valid;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [2:0]  alu_ctr;
  logic [4:0]  ex_rd, ex_ctl;
  logic        load_use_haz;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_alu_ctr(id_alu_ctr), .id_alu_src(id_alu_src), .id_ctl(id_ctl),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_res(exm_res),
    .mw_reg_write(mw_reg_write), .mw_rd(mw_rd), .mw_wdata(mw_wdata),
    .ex_valid(ex_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_ctr(alu_ctr), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_ctl(ex_ctl), .load_use_haz(load_use_haz)
  );

  typedef struct {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [2:0]  alu;
    logic        src;
    logic [4:0]  ctl;
    logic        exm_rw;
    logic [4:0]  exm_rd;
    logic [31:0] exm_res;
    logic        mw_rw;
    logic [4:0]  mw_rd;
    logic [31:0] mw_wd;
    logic [31:0] e_in1_fwd, e_in2_fwd, e_sd_fwd;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [2:0]  alu;
    logic [4:0]  rd, ctl;
    logic [31:0] in1, in2, sd;
    logic        chk_data;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [2:0] alu, input logic src,
                          input logic [4:0] ctl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_ctr = alu; id_alu_src = src; id_ctl = ctl;
  endtask

  task automatic set_ex(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                        input logic mrw, input logic [4:0] mrd, input logic [31:0] mwd);
    exm_reg_write = erw; exm_rd = erd; exm_res = eres;
    mw_reg_write = mrw; mw_rd = mrd; mw_wdata = mwd;
  endtask

  function automatic exp_t exp_of(input vec_t v);
    exp_t e;
    e.valid    = v.valid;
    e.chk_data = v.valid;
    e.alu      = v.valid ? v.alu : 3'b111;
    e.rd       = v.valid ? v.rd : 5'd0;
    e.ctl      = v.valid ? v.ctl : 5'd0;
`ifdef ID_EX_FWD_EN
    e.in1 = v.e_in1_fwd;
    e.in2 = v.e_in2_fwd;
    e.sd  = v.e_sd_fwd;
`else
    e.in1 = v.rsd;
    e.in2 = v.src ? v.imm : v.rtd;
    e.sd  = v.rtd;
`endif
    return e;
  endfunction

  initial begin
    exp_t e;
    logic fwd_on;
`ifdef ID_EX_FWD_EN
    fwd_on = 1'b1;
`else
    fwd_on = 1'b0;
`endif

    vecs[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b010, 1'b0, 5'b10000,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7};
    vecs[1] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b001, 1'b0, 5'b10000,
                1'b1, 5'd1, 32'h10, 1'b1, 5'd1, 32'h20, 32'h10, 32'd7, 32'd7};
    vecs[2] = '{1'b1, 5'd0, 5'd2, 5'd9, 32'd0, 32'd7, 32'd0, 3'b011, 1'b0, 5'b10000,
                1'b1, 5'd0, 32'h10, 1'b1, 5'd2, 32'h20, 32'd0, 32'h20, 32'h20};
    vecs[3] = '{1'b1, 5'd1, 5'd2, 5'd0, 32'd5, 32'd7, 32'hFFFF_FFFC, 3'b110, 1'b1, 5'b00100,
                1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h20, 32'd5, 32'hFFFF_FFFC, 32'h20};
    vecs[4] = '{1'b1, 5'd4, 5'd6, 5'd7, 32'h40, 32'h60, 32'd0, 3'b100, 1'b0, 5'b10000,
                1'b1, 5'd6, 32'hAA, 1'b1, 5'd4, 32'hBB, 32'hBB, 32'hAA, 32'hAA};
    vecs[5] = '{1'b1, 5'd4, 5'd6, 5'd8, 32'h40, 32'h60, 32'd0, 3'b000, 1'b0, 5'b00001,
                1'b0, 5'd4, 32'hAA, 1'b0, 5'd6, 32'hBB, 32'h40, 32'h60, 32'h60};
    vecs[6] = '{1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b010, 1'b0, 5'b10000,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vecs[7] = '{1'b1, 5'd31, 5'd31, 5'd31, 32'h1234, 32'h5678, 32'h10, 3'b010, 1'b1, 5'b11010,
                1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1, 5'd31, 32'hCAFE, 32'hDEAD_BEEF, 32'h10, 32'hDEAD_BEEF};

    // Reset held with a valid-looking ID slot
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd9, 3'b010, 1'b1, 5'b11111);
    set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (3) cyc();
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_ctr", 32'(alu_ctr), 32'd7);
    chk("rst_ex_ctl", 32'(ex_ctl), 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_in2", alu_in2, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_haz", 32'(load_use_haz), 32'd0);
    id_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Table: capture in one cycle, check in the next with EX-side inputs applied
    foreach (vecs[i]) begin
      drive_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rsd, vecs[i].rtd,
               vecs[i].imm, vecs[i].alu, vecs[i].src, vecs[i].ctl);
      set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      sb.push_back(exp_of(vecs[i]));
      cyc();
      id_valid = 1'b0;
      set_ex(vecs[i].exm_rw, vecs[i].exm_rd, vecs[i].exm_res,
             vecs[i].mw_rw, vecs[i].mw_rd, vecs[i].mw_wd);
      #1;
      e = sb.pop_front();
      chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(e.valid));
      chk($sformatf("v%0d_alu_ctr", i), 32'(alu_ctr), 32'(e.alu));
      chk($sformatf("v%0d_ex_rd", i), 32'(ex_rd), 32'(e.rd));
      chk($sformatf("v%0d_ex_ctl", i), 32'(ex_ctl), 32'(e.ctl));
      chk($sformatf("v%0d_haz", i), 32'(load_use_haz), 32'd0);
      if (e.chk_data) begin
        chk($sformatf("v%0d_alu_in1", i), alu_in1, e.in1);
        chk($sformatf("v%0d_alu_in2", i), alu_in2, e.in2);
        chk($sformatf("v%0d_store", i), ex_store_data, e.sd);
      end
      cyc();
    end
    set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc();

    // Stall together with flush: flush wins -> bubble
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'd0, 3'b010, 1'b0, 5'b10000);
    cyc();
    drive_id(1'b1, 5'd8, 5'd9, 5'd10, 32'h88, 32'h99, 32'd0, 3'b001, 1'b0, 5'b10000);
    stall = 1'b1; flush = 1'b1;
    cyc();
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    #1;
    chk("sf_ex_valid", 32'(ex_valid), 32'd0);
    chk("sf_ex_ctl", 32'(ex_ctl), 32'd0);
    chk("sf_ex_rd", 32'(ex_rd), 32'd0);
    chk("sf_alu_ctr", 32'(alu_ctr), 32'd7);

    // Stall alone for 3 cycles: EX contents held, ID changes ignored
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'd0, 3'b110, 1'b0, 5'b10000);
    cyc();
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      drive_id(1'b1, 5'(k + 4), 5'(k + 7), 5'(k + 12), 32'(k + 32'h500), 32'(k + 32'h600),
               32'h77, 3'b000, 1'b1, 5'b01000);
      if (k > 0) begin
        #1;
      end
      chk($sformatf("st%0d_ex_valid", k), 32'(ex_valid), 32'd1);
      chk($sformatf("st%0d_alu_ctr", k), 32'(alu_ctr), 32'd6);
      chk($sformatf("st%0d_alu_in1", k), alu_in1, 32'h11);
      chk($sformatf("st%0d_alu_in2", k), alu_in2, 32'h22);
      chk($sformatf("st%0d_ex_rd", k), 32'(ex_rd), 32'd3);
      chk($sformatf("st%0d_ex_ctl", k), 32'(ex_ctl), 32'b10000);
      cyc();
    end
    #1;
    chk("st_end_alu_in1", alu_in1, 32'h11);
    chk("st_end_ex_rd", 32'(ex_rd), 32'd3);
    stall = 1'b0; id_valid = 1'b0;
    cyc();

    // Load-use: lw $4 in EX, sub $5,$4,$6 in ID
    drive_id(1'b1, 5'd1, 5'd4, 5'd4, 32'h5, 32'h0, 32'h8, 3'b010, 1'b1, 5'b11010);
    cyc();
    drive_id(1'b1, 5'd4, 5'd6, 5'd5, 32'h111, 32'h66, 32'd0, 3'b110, 1'b0, 5'b10000);
    #1;
    chk("lu_haz_first", 32'(load_use_haz), 32'd1);
    cyc();
    if (fwd_on) begin
      #1;
      chk("lu_haz_after", 32'(load_use_haz), 32'd0);
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_alu", 32'(alu_ctr), 32'd7);
      chk("lu_bubble_ctl", 32'(ex_ctl), 32'd0);
      cyc();
      set_ex(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
      id_valid = 1'b0;
      #1;
    end else begin
      set_ex(1'b1, 5'd4, 32'h9, 1'b0, 5'd0, 32'd0);
      #1;
      chk("lu_haz_exm", 32'(load_use_haz), 32'd1);
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      cyc();
      set_ex(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
      id_rs_data = 32'h44;
      #1;
      chk("lu_haz_after", 32'(load_use_haz), 32'd0);
      chk("lu_bubble2_valid", 32'(ex_valid), 32'd0);
      cyc();
      id_valid = 1'b0;
      set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #1;
    end
    chk("lu_sub_valid", 32'(ex_valid), 32'd1);
    chk("lu_sub_in1", alu_in1, 32'h44);
    chk("lu_sub_in2", alu_in2, 32'h66);
    chk("lu_sub_alu", 32'(alu_ctr), 32'd6);
    chk("lu_sub_rd", 32'(ex_rd), 32'd5);
    set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc();
    cyc();

    // ALU-result RAW: add $3 in EX, ID reads $3
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 3'b010, 1'b0, 5'b10000);
    cyc();
    drive_id(1'b1, 5'd3, 5'd1, 5'd7, 32'h33, 32'h5, 32'd0, 3'b001, 1'b0, 5'b10000);
    set_ex(1'b1, 5'd1, 32'h99, 1'b0, 5'd0, 32'd0);
    #1;
    chk("raw_haz", 32'(load_use_haz), fwd_on ? 32'd0 : 32'd1);
    chk("raw_alu_in1", alu_in1, fwd_on ? 32'h99 : 32'd5);
    cyc();
    id_valid = 1'b0;
    set_ex(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cyc();
    cyc();

    // Async reset mid-operation clears EX immediately
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 32'hAB, 32'hCD, 32'd0, 3'b011, 1'b0, 5'b10000);
    cyc();
    id_valid = 1'b0;
    #1;
    chk("mid_pre_valid", 32'(ex_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_alu", 32'(alu_ctr), 32'd7);
    chk("mid_rst_ctl", 32'(ex_ctl), 32'd0);
    chk("mid_rst_in1", alu_in1, 32'd0);
    rst_n = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
